// File: rtl/llc_input_sched_pkg.sv
// Shared constants and types for the LLC front-end input scheduler.
// Holds set-walk geometry, the one-hot source select encoding and the FSM states.
package llc_input_sched_pkg;

    localparam int LLC_SETS = 256;
    localparam int SET_BITS = 8;

    typedef logic [SET_BITS-1:0] llc_set_t;

    typedef enum logic [4:0] {
        SEL_NONE   = 5'b00000,
        SEL_RST    = 5'b00001,
        SEL_RSP    = 5'b00010,
        SEL_REQ    = 5'b00100,
        SEL_DMA    = 5'b01000,
        SEL_RESUME = 5'b10000
    } sched_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RST_WALK   = 2'd1,
        ST_FLUSH_WALK = 2'd2
    } llc_sched_state_t;

endpackage

// File: rtl/llc_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer always moves to the requester
// that did not win, so a lone winner also hands priority to the other side.
module llc_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b
);

    logic ptr_b_r;

    // Grant the pointer owner on a tie, otherwise whichever side is requesting.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                grant_a = !ptr_b_r;
                grant_b = ptr_b_r;
            end else begin
                grant_a = req_a;
                grant_b = req_b;
            end
        end else begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end
    end

    // Pointer update: hand priority to the loser after every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_b_r <= 1'b0;
        end else if (grant_a) begin
            ptr_b_r <= 1'b1;
        end else if (grant_b) begin
            ptr_b_r <= 1'b0;
        end else begin
            ptr_b_r <= ptr_b_r;
        end
    end

endmodule

// File: rtl/llc_input_sched.sv
// LLC front-end scheduler: strict-priority grant of rst/rsp/resume/req/dma into
// one decode slot, plus atomic reset/flush walks over every set.
module llc_input_sched #(
    parameter int LLC_SETS = llc_input_sched_pkg::LLC_SETS,
    parameter int SET_BITS = llc_input_sched_pkg::SET_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_in_valid,
    input  logic                rst_in_is_flush,
    input  logic                rsp_in_valid,
    input  logic                req_in_valid,
    input  logic                dma_req_in_valid,
    input  logic                fifo_full,
    input  logic                req_stall,
    input  logic                recall_pending,
    input  logic                dma_read_pending,
    input  logic                dma_write_pending,
    input  logic                is_dma_to_resume,
    output logic                rst_in_ready,
    output logic                rsp_in_ready,
    output logic                req_in_ready,
    output logic                dma_req_in_ready,
    output logic                decode_en,
    output logic [4:0]          sel,
    output logic                rst_state,
    output logic                set_flush_stall,
    output logic                walk_valid,
    output logic [SET_BITS-1:0] walk_set,
    output logic                walk_is_flush,
    output logic                clr_rst_stall,
    output logic                clr_flush_stall
);

    import llc_input_sched_pkg::*;

    llc_sched_state_t      state_r;
    logic [SET_BITS-1:0]   walk_cnt_r;

    logic rst_ok_s, resume_ok_s, req_elig_s, dma_elig_s;
    logic grant_rst_s, grant_rsp_s, grant_resume_s, arb_en_s;
    logic grant_req_s, grant_dma_s, last_beat_s;

    // A reset/flush may only start once no recall or DMA burst is in flight.
    assign rst_ok_s    = rst_in_valid && !recall_pending && !dma_read_pending && !dma_write_pending;
    assign resume_ok_s = is_dma_to_resume && !recall_pending;
    assign req_elig_s  = req_in_valid && !req_stall;
    assign dma_elig_s  = dma_req_in_valid && !dma_read_pending && !dma_write_pending && !is_dma_to_resume;
    assign last_beat_s = (walk_cnt_r == SET_BITS'(LLC_SETS - 1));

    // Strict priority among the fixed sources; req/dma fall through to the RR arbiter.
    always_comb begin
        grant_rst_s    = 1'b0;
        grant_rsp_s    = 1'b0;
        grant_resume_s = 1'b0;
        arb_en_s       = 1'b0;
        if (state_r == ST_IDLE && !fifo_full) begin
            if (rst_ok_s) begin
                grant_rst_s = 1'b1;
            end else if (rsp_in_valid) begin
                grant_rsp_s = 1'b1;
            end else if (resume_ok_s) begin
                grant_resume_s = 1'b1;
            end else begin
                arb_en_s = 1'b1;
            end
        end else begin
            arb_en_s = 1'b0;
        end
    end

    llc_rr_arb2 u_rr_arb (
        .clk     (clk),
        .rst_n   (rst),
        .en      (arb_en_s),
        .req_a   (req_elig_s),
        .req_b   (dma_elig_s),
        .grant_a (grant_req_s),
        .grant_b (grant_dma_s)
    );

    assign rst_in_ready     = grant_rst_s;
    assign rsp_in_ready     = grant_rsp_s;
    assign req_in_ready     = grant_req_s;
    assign dma_req_in_ready = grant_dma_s;

    // Scheduler FSM with registered handshake, pulse and walk-beat outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            walk_cnt_r      <= {SET_BITS{1'b0}};
            decode_en       <= 1'b0;
            sel             <= SEL_NONE;
            rst_state       <= 1'b0;
            set_flush_stall <= 1'b0;
            walk_valid      <= 1'b0;
            walk_set        <= {SET_BITS{1'b0}};
            walk_is_flush   <= 1'b0;
            clr_rst_stall   <= 1'b0;
            clr_flush_stall <= 1'b0;
        end else begin
            decode_en       <= 1'b0;
            sel             <= SEL_NONE;
            rst_state       <= 1'b0;
            set_flush_stall <= 1'b0;
            walk_valid      <= 1'b0;
            walk_is_flush   <= 1'b0;
            clr_rst_stall   <= 1'b0;
            clr_flush_stall <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_rst_s) begin
                        sel <= SEL_RST;
                        if (rst_in_is_flush) begin
                            set_flush_stall <= 1'b1;
                            state_r         <= ST_FLUSH_WALK;
                        end else begin
                            rst_state <= 1'b1;
                            state_r   <= ST_RST_WALK;
                        end
                    end else if (grant_rsp_s) begin
                        decode_en <= 1'b1;
                        sel       <= SEL_RSP;
                    end else if (grant_resume_s) begin
                        decode_en <= 1'b1;
                        sel       <= SEL_RESUME;
                    end else if (grant_req_s) begin
                        decode_en <= 1'b1;
                        sel       <= SEL_REQ;
                    end else if (grant_dma_s) begin
                        decode_en <= 1'b1;
                        sel       <= SEL_DMA;
                    end
                end
                ST_RST_WALK, ST_FLUSH_WALK: begin
                    // fifo_full stalls the walk without dropping a set.
                    if (!fifo_full) begin
                        walk_valid    <= 1'b1;
                        walk_set      <= walk_cnt_r;
                        walk_is_flush <= (state_r == ST_FLUSH_WALK);
                        if (last_beat_s) begin
                            walk_cnt_r <= {SET_BITS{1'b0}};
                            state_r    <= ST_IDLE;
                            if (state_r == ST_FLUSH_WALK) begin
                                clr_flush_stall <= 1'b1;
                            end else begin
                                clr_rst_stall <= 1'b1;
                            end
                        end else begin
                            walk_cnt_r <= walk_cnt_r + SET_BITS'(1);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    walk_cnt_r <= {SET_BITS{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llc_input_sched.sv
// Directed bench for llc_input_sched with a behavioural scoreboard model
// checked every cycle, plus literal expectations for each scenario.
module tb_llc_input_sched;

    localparam int SETS = 4;
    localparam int SB   = 2;

    logic clk = 1'b0;
    logic rst;
    logic rst_in_valid = 1'b0, rst_in_is_flush = 1'b0, rsp_in_valid = 1'b0;
    logic req_in_valid = 1'b0, dma_req_in_valid = 1'b0, fifo_full = 1'b0;
    logic req_stall = 1'b0, recall_pending = 1'b0, dma_read_pending = 1'b0;
    logic dma_write_pending = 1'b0, is_dma_to_resume = 1'b0;
    logic rst_in_ready, rsp_in_ready, req_in_ready, dma_req_in_ready;
    logic decode_en, rst_state, set_flush_stall, walk_valid, walk_is_flush;
    logic clr_rst_stall, clr_flush_stall;
    logic [4:0]    sel;
    logic [SB-1:0] walk_set;

    llc_input_sched #(.LLC_SETS(SETS), .SET_BITS(SB)) dut (
        .clk(clk), .rst(rst),
        .rst_in_valid(rst_in_valid), .rst_in_is_flush(rst_in_is_flush),
        .rsp_in_valid(rsp_in_valid), .req_in_valid(req_in_valid),
        .dma_req_in_valid(dma_req_in_valid), .fifo_full(fifo_full),
        .req_stall(req_stall), .recall_pending(recall_pending),
        .dma_read_pending(dma_read_pending), .dma_write_pending(dma_write_pending),
        .is_dma_to_resume(is_dma_to_resume),
        .rst_in_ready(rst_in_ready), .rsp_in_ready(rsp_in_ready),
        .req_in_ready(req_in_ready), .dma_req_in_ready(dma_req_in_ready),
        .decode_en(decode_en), .sel(sel), .rst_state(rst_state),
        .set_flush_stall(set_flush_stall), .walk_valid(walk_valid),
        .walk_set(walk_set), .walk_is_flush(walk_is_flush),
        .clr_rst_stall(clr_rst_stall), .clr_flush_stall(clr_flush_stall)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int walk_log[$];
    int grant_log[$];
    int n_clr_rst = 0;
    int n_clr_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model state: mode 0 idle, 1 reset walk, 2 flush walk.
    int            m_mode = 0;
    int            m_count = 0;
    bit            m_ptr_req = 1'b1;
    logic          m_dec = 1'b0, m_rs = 1'b0, m_fs = 1'b0, m_wv = 1'b0;
    logic          m_wf = 1'b0, m_cr = 1'b0, m_cf = 1'b0;
    logic [4:0]    m_sel = 5'd0;
    logic [SB-1:0] m_ws = '0;

    // 0 none, 1 rst, 2 rsp, 3 resume, 4 req, 5 dma
    function automatic int exp_grant();
        bit re, de;
        if (m_mode != 0 || fifo_full) return 0;
        if (rst_in_valid && !recall_pending && !dma_read_pending && !dma_write_pending) return 1;
        if (rsp_in_valid) return 2;
        if (is_dma_to_resume && !recall_pending) return 3;
        re = req_in_valid && !req_stall;
        de = dma_req_in_valid && !dma_read_pending && !dma_write_pending && !is_dma_to_resume;
        if (re && de) return m_ptr_req ? 4 : 5;
        if (re) return 4;
        if (de) return 5;
        return 0;
    endfunction

    function automatic logic [31:0] dut_regs();
        return {18'd0, decode_en, sel, rst_state, set_flush_stall, walk_valid, walk_set,
                walk_is_flush, clr_rst_stall, clr_flush_stall};
    endfunction

    function automatic logic [31:0] pack_log(input bit grants);
        logic [31:0] p;
        p = 32'd0;
        if (grants) begin
            foreach (grant_log[i]) p = (p << 8) | 32'(grant_log[i] & 255);
        end else begin
            foreach (walk_log[i]) p = (p << 4) | 32'(walk_log[i] & 15);
        end
        return p;
    endfunction

    always @(posedge clk or negedge rst) begin
        int g;
        if (!rst) begin
            m_mode = 0; m_count = 0; m_ptr_req = 1'b1;
            m_dec = 1'b0; m_sel = 5'd0; m_rs = 1'b0; m_fs = 1'b0; m_wv = 1'b0;
            m_ws = '0; m_wf = 1'b0; m_cr = 1'b0; m_cf = 1'b0;
        end else begin
            g = exp_grant();
            m_dec = 1'b0; m_sel = 5'd0; m_rs = 1'b0; m_fs = 1'b0;
            m_wv = 1'b0; m_wf = 1'b0; m_cr = 1'b0; m_cf = 1'b0;
            if (m_mode == 0) begin
                case (g)
                    1: begin
                        m_sel = 5'd1;
                        if (rst_in_is_flush) begin m_fs = 1'b1; m_mode = 2; end
                        else begin m_rs = 1'b1; m_mode = 1; end
                    end
                    2: begin m_dec = 1'b1; m_sel = 5'd2; end
                    3: begin m_dec = 1'b1; m_sel = 5'd16; end
                    4: begin m_dec = 1'b1; m_sel = 5'd4; m_ptr_req = 1'b0; end
                    5: begin m_dec = 1'b1; m_sel = 5'd8; m_ptr_req = 1'b1; end
                    default: ;
                endcase
            end else if (!fifo_full) begin
                m_wv = 1'b1;
                m_ws = SB'(m_count);
                m_wf = (m_mode == 2);
                m_count++;
                if (m_count == SETS) begin
                    if (m_mode == 1) m_cr = 1'b1; else m_cf = 1'b1;
                    m_count = 0;
                    m_mode = 0;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        int g;
        g = exp_grant();
        check("ready", {28'd0, dma_req_in_ready, req_in_ready, rsp_in_ready, rst_in_ready},
              {28'd0, g == 5, g == 4, g == 2, g == 1});
        check("regs", dut_regs(),
              {18'd0, m_dec, m_sel, m_rs, m_fs, m_wv, m_ws, m_wf, m_cr, m_cf});
        if (walk_valid) walk_log.push_back(int'(walk_set));
        if (decode_en) grant_log.push_back(int'(sel));
        if (clr_rst_stall) n_clr_rst++;
        if (clr_flush_stall) n_clr_flush++;
    end

    initial begin
        rst = 1'b0;
        cyc(3);
        check("reset_outs", dut_regs(), 32'd0);
        rst = 1'b1;
        cyc(2);

        // Reset walk over 4 sets.
        walk_log.delete(); n_clr_rst = 0;
        rst_in_valid = 1'b1;
        #1 check("rst_ready", {31'd0, rst_in_ready}, 32'd1);
        cyc(1);
        check("rst_state_pulse", {31'd0, rst_state}, 32'd1);
        rst_in_valid = 1'b0;
        cyc(7);
        check("rst_walk_len", 32'(walk_log.size()), 32'd4);
        check("rst_walk_seq", pack_log(1'b0), 32'h0123);
        check("clr_rst_count", 32'(n_clr_rst), 32'd1);

        // Flush walk stalled for two cycles after beat 1.
        walk_log.delete(); n_clr_flush = 0;
        rst_in_valid = 1'b1; rst_in_is_flush = 1'b1;
        cyc(1);
        check("flush_pulse", {31'd0, set_flush_stall}, 32'd1);
        rst_in_valid = 1'b0; rst_in_is_flush = 1'b0;
        cyc(2);
        fifo_full = 1'b1;
        cyc(2);
        check("flush_hold", {30'd0, walk_valid, walk_set == 2'd1}, 32'd1);
        fifo_full = 1'b0;
        cyc(6);
        check("flush_walk_len", 32'(walk_log.size()), 32'd4);
        check("flush_walk_seq", pack_log(1'b0), 32'h0123);
        check("clr_flush_count", 32'(n_clr_flush), 32'd1);

        // req and dma together alternate.
        grant_log.delete();
        req_in_valid = 1'b1; dma_req_in_valid = 1'b1;
        cyc(4);
        req_in_valid = 1'b0; dma_req_in_valid = 1'b0;
        cyc(2);
        check("rr_len", 32'(grant_log.size()), 32'd4);
        check("rr_seq", pack_log(1'b1), 32'h04080408);

        // rsp beats req/dma; a stalled req loses to dma.
        grant_log.delete();
        rsp_in_valid = 1'b1; req_in_valid = 1'b1; dma_req_in_valid = 1'b1;
        cyc(1);
        rsp_in_valid = 1'b0; req_stall = 1'b1;
        cyc(1);
        req_in_valid = 1'b0; dma_req_in_valid = 1'b0; req_stall = 1'b0;
        cyc(2);
        check("prio_seq", pack_log(1'b1), 32'h0208);

        // Resume slot takes precedence and blocks dma.
        grant_log.delete();
        is_dma_to_resume = 1'b1; dma_req_in_valid = 1'b1;
        #1 check("resume_no_dma_ready", {31'd0, dma_req_in_ready}, 32'd0);
        cyc(1);
        is_dma_to_resume = 1'b0; dma_req_in_valid = 1'b0;
        cyc(1);
        check("resume_seq", pack_log(1'b1), 32'h10);

        // rst held off by recall; rsp still served; rst granted once recall drops.
        grant_log.delete(); walk_log.delete(); n_clr_rst = 0;
        rst_in_valid = 1'b1; recall_pending = 1'b1; rsp_in_valid = 1'b1;
        #1 check("rst_held_readies", {30'd0, rst_in_ready, rsp_in_ready}, 32'd1);
        cyc(1);
        rsp_in_valid = 1'b0; recall_pending = 1'b0;
        #1 check("rst_after_recall", {31'd0, rst_in_ready}, 32'd1);
        cyc(1);
        rst_in_valid = 1'b0;
        cyc(7);
        check("recall_grants", pack_log(1'b1), 32'h02);
        check("recall_walk_len", 32'(walk_log.size()), 32'd4);
        check("recall_clr_rst", 32'(n_clr_rst), 32'd1);

        // Async reset in the middle of a walk.
        walk_log.delete(); n_clr_rst = 0;
        rst_in_valid = 1'b1;
        cyc(1);
        rst_in_valid = 1'b0;
        cyc(3);
        check("midwalk_set2", {29'd0, walk_valid, walk_set}, 32'h6);
        rst = 1'b0;
        #1 check("midwalk_reset_outs", dut_regs(), 32'd0);
        cyc(2);
        rst = 1'b1;
        req_in_valid = 1'b1;
        #1 check("post_reset_req_ready", {31'd0, req_in_ready}, 32'd1);
        cyc(1);
        check("post_reset_sel", {26'd0, decode_en, sel}, 32'h24);
        req_in_valid = 1'b0;
        cyc(3);
        check("midwalk_no_clr", 32'(n_clr_rst), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
